// File: rtl/conv_step_sequencer.sv
// conv_step_sequencer
//   Sequences one convolution layer pass for the PE address controller array.
//   Iteration order, innermost first: kernel column (kx), kernel row (ky),
//   input channel (ch), OFM tile. Each RUN cycle with en=1 is one step. On a
//   step the sequencer drives the per-lane valid strobes and at most one of
//   the change_row / change_channel / end_OFM events.
//
// Ports
//   clk            rising-edge clock
//   reset_n        synchronous reset, active-high (1 = reset asserted)
//   start          single-cycle pulse. When idle, it latches cfg_* and
//                  begins a pass.
//   en             advance enable; 0 stalls the sequence
//   cfg_kernel     kernel size K (KxK window); 0 is treated as 1
//   cfg_channels   input channel count C; 0 is treated as 1
//   cfg_tiles      OFM tile count T; 0 is treated as 1
//   cfg_pe_mask    lanes that are active for this pass
//   valid          per-lane step strobe (the latched mask on each step)
//   change_row     kernel-row advance event
//   change_channel channel advance event
//   end_OFM        tile complete event (fires for every tile)
//   busy           high in LOAD and RUN
//   done           one-cycle pulse after the last step
//   tile_idx       current tile index while in RUN, otherwise 0
module conv_step_sequencer #(
    parameter int NUM_PE = 16,
    parameter int CNT_W  = 9,
    parameter int K_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              en,
    input  logic [K_W-1:0]    cfg_kernel,
    input  logic [CNT_W-1:0]  cfg_channels,
    input  logic [CNT_W-1:0]  cfg_tiles,
    input  logic [NUM_PE-1:0] cfg_pe_mask,
    output logic [NUM_PE-1:0] valid,
    output logic              change_row,
    output logic              change_channel,
    output logic              end_OFM,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tile_idx
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state;
    logic [K_W-1:0]     kx, ky, k_lat;
    logic [CNT_W-1:0]   ch, tile, c_lat, t_lat;
    logic [NUM_PE-1:0]  mask_lat;

    logic kx_last, ky_last, ch_last, tile_last;
    logic step;

    assign kx_last   = (kx   == k_lat - K_W'(1));
    assign ky_last   = (ky   == k_lat - K_W'(1));
    assign ch_last   = (ch   == c_lat - CNT_W'(1));
    assign tile_last = (tile == t_lat - CNT_W'(1));

    // Outputs are forced low during the reset cycle itself. This keeps an
    // aborted pass from leaking an event or done pulse before the FSM
    // returns to IDLE.
    assign step = (state == RUN) && en && !reset_n;

    always_comb begin
        valid          = '0;
        change_row     = 1'b0;
        change_channel = 1'b0;
        end_OFM        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        tile_idx       = '0;
        if (!reset_n) begin
            busy     = (state == LOAD) || (state == RUN);
            done     = (state == DONE);
            tile_idx = (state == RUN) ? tile : '0;
        end
        if (step) begin
            valid          = mask_lat;
            // Only the highest wrapping level reports.
            change_row     = kx_last && !ky_last;
            change_channel = kx_last &&  ky_last && !ch_last;
            end_OFM        = kx_last &&  ky_last &&  ch_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state    <= IDLE;
            kx       <= '0;
            ky       <= '0;
            ch       <= '0;
            tile     <= '0;
            k_lat    <= '0;
            c_lat    <= '0;
            t_lat    <= '0;
            mask_lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // A size of 0 is clamped to 1 so the pass always terminates.
                        k_lat    <= (cfg_kernel   == '0) ? K_W'(1)   : cfg_kernel;
                        c_lat    <= (cfg_channels == '0) ? CNT_W'(1) : cfg_channels;
                        t_lat    <= (cfg_tiles    == '0) ? CNT_W'(1) : cfg_tiles;
                        mask_lat <= cfg_pe_mask;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    kx    <= '0;
                    ky    <= '0;
                    ch    <= '0;
                    tile  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (en) begin
                        if (kx_last) begin
                            kx <= '0;
                            if (ky_last) begin
                                ky <= '0;
                                if (ch_last) begin
                                    ch <= '0;
                                    if (tile_last) begin
                                        tile  <= '0;
                                        state <= DONE;
                                    end else begin
                                        tile <= tile + CNT_W'(1);
                                    end
                                end else begin
                                    ch <= ch + CNT_W'(1);
                                end
                            end else begin
                                ky <= ky + K_W'(1);
                            end
                        end else begin
                            kx <= kx + K_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_step_sequencer.sv
module tb_conv_step_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        en;
    logic [3:0]  cfg_kernel;
    logic [8:0]  cfg_channels;
    logic [8:0]  cfg_tiles;
    logic [15:0] cfg_pe_mask;
    logic [15:0] valid;
    logic        change_row, change_channel, end_OFM, busy, done;
    logic [8:0]  tile_idx;

    always #5 clk = ~clk;

    conv_step_sequencer #(.NUM_PE(16), .CNT_W(9), .K_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .en(en),
        .cfg_kernel(cfg_kernel), .cfg_channels(cfg_channels),
        .cfg_tiles(cfg_tiles), .cfg_pe_mask(cfg_pe_mask),
        .valid(valid), .change_row(change_row), .change_channel(change_channel),
        .end_OFM(end_OFM), .busy(busy), .done(done), .tile_idx(tile_idx)
    );

    typedef struct packed {
        logic [15:0] v;
        logic        cr;
        logic        cc;
        logic        eo;
        logic        dn;
        logic        bz;
        logic [8:0]  ti;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int n_valid, n_cr, n_cc, n_eo, n_done, n_busy, done_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected entry whenever the DUT presents a step or done.
    always @(negedge clk) begin
        exp_t a, e;
        if (busy) n_busy++;
        if (valid != '0 || change_row || change_channel || end_OFM || done) begin
            a = '{valid, change_row, change_channel, end_OFM, done, busy, tile_idx};
            if (valid != '0) n_valid++;
            if (change_row) n_cr++;
            if (change_channel) n_cc++;
            if (end_OFM) n_eo++;
            if (done) begin n_done++; done_cyc = cyc; end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output cyc=%0d got v=%h cr=%b cc=%b eo=%b dn=%b, required nothing",
                         cyc, valid, change_row, change_channel, end_OFM, done);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL step_output cyc=%0d got v=%h cr=%b cc=%b eo=%b dn=%b bz=%b ti=%0d, required v=%h cr=%b cc=%b eo=%b dn=%b bz=%b ti=%0d",
                             cyc, a.v, a.cr, a.cc, a.eo, a.dn, a.bz, a.ti,
                             e.v, e.cr, e.cc, e.eo, e.dn, e.bz, e.ti);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected step list for one pass, walked in kx/ky/ch/tile order, followed by done.
    task automatic push_pass(input int k, input int c, input int t, input logic [15:0] m);
        exp_t e;
        for (int ti = 0; ti < t; ti++)
            for (int ch = 0; ch < c; ch++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        e.v  = m;
                        e.cr = (kx == k-1) && (ky != k-1);
                        e.cc = (kx == k-1) && (ky == k-1) && (ch != c-1);
                        e.eo = (kx == k-1) && (ky == k-1) && (ch == c-1);
                        e.dn = 1'b0;
                        e.bz = 1'b1;
                        e.ti = 9'(ti);
                        sb.push_back(e);
                    end
        e = '0;
        e.dn = 1'b1;
        sb.push_back(e);
    endtask

    task automatic clear_counts();
        n_valid = 0; n_cr = 0; n_cc = 0; n_eo = 0; n_done = 0; n_busy = 0; done_cyc = -1;
    endtask

    task automatic run_start(input logic [3:0] k, input logic [8:0] c, input logic [8:0] t,
                             input logic [15:0] m);
        clear_counts();
        cfg_kernel = k; cfg_channels = c; cfg_tiles = t; cfg_pe_mask = m;
        start = 1'b1;
        t0 = cyc;
        tick(1);
        start = 1'b0;
        cfg_kernel = 4'hF; cfg_channels = 9'h1FF; cfg_tiles = 9'h1FF; cfg_pe_mask = 16'h0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (n_done == 0 && n < budget) begin
            tick(1);
            n++;
        end
        tick(2);
        check({name, "_done_count"}, n_done, 1);
        check({name, "_queue_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        reset_n = 1'b1; start = 1'b0; en = 1'b1;
        cfg_kernel = '0; cfg_channels = '0; cfg_tiles = '0; cfg_pe_mask = '0;
        clear_counts();
        tick(2);
        @(negedge clk);
        check("reset_outputs", int'({valid, change_row, change_channel, end_OFM, busy, done, tile_idx}), 0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        tick(2);
        check("idle_busy", int'(busy), 0);

        // Basic pass: K=3 C=2 T=1
        push_pass(3, 2, 1, 16'hFFFF);
        run_start(4'd3, 9'd2, 9'd1, 16'hFFFF);
        wait_done("basic", 40);
        check("basic_steps", n_valid, 18);
        check("basic_change_row", n_cr, 4);
        check("basic_change_channel", n_cc, 1);
        check("basic_end_ofm", n_eo, 1);
        check("basic_done_cycle", done_cyc - t0, 20);
        check("basic_busy_cycles", n_busy, 19);

        // Stall for steps 4..6
        push_pass(3, 2, 1, 16'hFFFF);
        run_start(4'd3, 9'd2, 9'd1, 16'hFFFF);
        tick(4);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        wait_done("stall", 40);
        check("stall_steps", n_valid, 18);
        check("stall_change_row", n_cr, 4);
        check("stall_done_cycle", done_cyc - t0, 23);

        // Multi-tile: K=2 C=1 T=3
        push_pass(2, 1, 3, 16'h001F);
        run_start(4'd2, 9'd1, 9'd3, 16'h001F);
        wait_done("tiles", 40);
        check("tiles_steps", n_valid, 12);
        check("tiles_end_ofm", n_eo, 3);
        check("tiles_change_channel", n_cc, 0);
        check("tiles_done_cycle", done_cyc - t0, 14);

        // Zero config clamps to 1,1,1
        push_pass(1, 1, 1, 16'hA5A5);
        run_start(4'd0, 9'd0, 9'd0, 16'hA5A5);
        wait_done("clamp", 20);
        check("clamp_steps", n_valid, 1);
        check("clamp_end_ofm", n_eo, 1);
        check("clamp_done_cycle", done_cyc - t0, 3);

        // K=1, C=4
        push_pass(1, 4, 1, 16'h8001);
        run_start(4'd1, 9'd4, 9'd1, 16'h8001);
        wait_done("k1", 20);
        check("k1_steps", n_valid, 4);
        check("k1_change_channel", n_cc, 3);
        check("k1_end_ofm", n_eo, 1);
        check("k1_change_row", n_cr, 0);

        // Restart while busy is ignored, then reset mid-pass
        push_pass(3, 2, 1, 16'hFFFF);
        run_start(4'd3, 9'd2, 9'd1, 16'hFFFF);
        tick(5);
        cfg_kernel = 4'd1; cfg_channels = 9'd1; cfg_tiles = 9'd1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        check("pre_reset_steps", n_valid, 9);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_midpass_outputs",
              int'({valid, change_row, change_channel, end_OFM, busy, done, tile_idx}), 0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("after_reset_outputs",
              int'({valid, change_row, change_channel, end_OFM, busy, done, tile_idx}), 0);
        tick(4);
        check("after_reset_no_done", n_done, 0);
        check("after_reset_steps", n_valid, 9);

        push_pass(3, 2, 1, 16'hFFFF);
        run_start(4'd3, 9'd2, 9'd1, 16'hFFFF);
        wait_done("fresh", 40);
        check("fresh_steps", n_valid, 18);
        check("fresh_done_cycle", done_cyc - t0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_step_sequencer.md
Name: conv_step_sequencer

Overview:
- Sequences one convolution layer pass for the 16-lane PE address controller array.
- Walks kernel column, then kernel row, then input channel, then OFM tile.
- Each cycle it issues the per-lane valid strobes and the change_row / change_channel / end_OFM events that the per-PE address generators consume.
- Sits between the layer-level control FSM (start/config) and the address controller array.

Parameters:
NUM_PE, 16, number of PE lanes (width of valid / cfg_pe_mask)
CNT_W, 9, width of channel and tile counters/config
K_W, 4, width of kernel-size config/counters

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  reset; synchronous, active-high (1 = reset asserted)
start  in  1  single-cycle pulse; latches cfg_* and begins a pass when idle
en  in  1  advance enable; 0 stalls the sequence
cfg_kernel  in  K_W  kernel size K (KxK window)
cfg_channels  in  CNT_W  input channel count C
cfg_tiles  in  CNT_W  OFM tile count T
cfg_pe_mask  in  NUM_PE  lanes active for this pass
valid  out  NUM_PE  per-lane step strobe
change_row  out  1  kernel-row advance pulse
change_channel  out  1  channel advance pulse
end_OFM  out  1  tile complete pulse
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle pulse after the last step
tile_idx  out  CNT_W  current tile index, 0-based

Behaviour:
- FSM states are IDLE, LOAD, RUN, DONE. Reset places the FSM in IDLE and clears all counters and latched config. Every output is 0 while reset is asserted and in IDLE.
- IDLE → LOAD: on start=1. Config is latched on that edge. A start in any other state is ignored.
- LOAD: lasts 1 cycle. Counters kx, ky, ch, tile are cleared. Next state is RUN.
- Config values of 0 are clamped to 1 at latch time (K, C, T ≥ 1). A cfg_pe_mask of 0 is legal: the sequence still runs, but valid stays 0.
- RUN, en=1: one step per cycle.
  - valid = latched mask.
  - kx increments.
  - On kx = K-1: kx wraps to 0 and ky increments.
  - On ky wrap: ch increments.
  - On ch wrap: tile increments.
- RUN, en=0: counters hold. valid, change_row, change_channel and end_OFM are all 0.
- Event outputs are combinational from the registered counters, the FSM state and en. They are asserted in the same cycle as the qualifying step, and only the highest level fires:
  - change_row = step with kx=K-1 and ky≠K-1.
  - change_channel = step with kx=K-1, ky=K-1, ch≠C-1.
  - end_OFM = step with kx=K-1, ky=K-1, ch=C-1, for every tile including the last.
  - At most one of the three is high in any cycle.
- Last step (end_OFM with tile=T-1): next state is DONE and counters clear.
- DONE: lasts 1 cycle. done=1 and busy=0. Next state is IDLE. A start arriving in DONE is ignored.
- Latency: start at cycle n gives LOAD at n+1 and the first valid at n+2 (when en=1). Total steps = K·K·C·T.
- tile_idx reflects the registered tile counter and is 0 outside RUN.
- Reset mid-pass: IDLE on the next edge. No done and no event pulses are emitted.
- K=1 case: every step has kx=ky=K-1, so every step is change_channel or end_OFM. change_row never fires.

Test Plan:
- Basic pass:
  - Stimulus: K=3, C=2, T=1, mask=16'hFFFF, en=1, start at cycle 0.
  - Response: valid=FFFF on cycles 2..19 (18 steps); change_row on steps 3,6,12,15; change_channel on step 9; end_OFM on step 18; done at cycle 20; busy cycles 1..19.
- Stall:
  - Stimulus: same config; en=0 for steps 4–6 (3 cycles).
  - Response: valid/events 0 during the stall; same event ordering; done delayed by 3 cycles, at cycle 23.
- Multi-tile:
  - Stimulus: K=2, C=1, T=3, mask=16'h001F.
  - Response: valid=001F for 12 steps; end_OFM on steps 4,8,12; change_channel never; tile_idx 0,1,2; single done.
- Clamp and edge:
  - Stimulus: K=0, C=0, T=0.
  - Response: treated as 1,1,1; exactly 1 step, with end_OFM=1 on that step; done on the following cycle.
- Start while busy and reset mid-pass:
  - Stimulus: start re-pulsed at step 5, then reset_n=1 at step 10.
  - Response: the re-start is ignored; after reset all outputs 0 and IDLE; no done; a fresh start then runs a full 18-step pass.
- K=1:
  - Stimulus: K=1, C=4, T=1.
  - Response: 4 steps; change_channel on steps 1–3, end_OFM on step 4, change_row never.
